// File: rtl/wb_writeback_if.sv
// Write-back unit bus bundle.
// Groups three channels:
//   wb_*  : config request, ack and done pulses from the main controller
//   res_* : valid/ready result word stream from the systolic array
//   mem_* : write port to the output SRAM, with a stall input
// Modports:
//   slave  : the write-back unit
//   master : the environment that drives config, results and SRAM stall
interface wb_writeback_if #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8,
  parameter int DATA_W = 32
);
  logic              wb_config_valid;
  logic [2:0]        wb_op;
  logic [ADDR_W-1:0] wb_src_addr;
  logic [DIM_W-1:0]  wb_row;
  logic [DIM_W-1:0]  wb_col;
  logic              wb_ack;
  logic              wb_done;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wait;

  modport slave (
    input  wb_config_valid, wb_op, wb_src_addr, wb_row, wb_col,
    input  res_valid, res_data, mem_wait,
    output wb_ack, wb_done, res_ready, mem_wr_en, mem_addr, mem_wdata
  );

  modport master (
    output wb_config_valid, wb_op, wb_src_addr, wb_row, wb_col,
    output res_valid, res_data, mem_wait,
    input  wb_ack, wb_done, res_ready, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/wb_writeback_unit.sv
// Write-back responder.
// Accepts a write-back job (base word address, row x col tile) on the config
// channel and acknowledges it. It then streams row*col result words from the
// systolic array into consecutive SRAM word addresses, wrapping at 2^ADDR_W.
// wb_done pulses once the last write has retired.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : wb_writeback_if.slave (config, result stream, SRAM write port)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for wb_config_valid; job fields captured on request
// ACK   | wb_ack high; decode op, size the tile
// XFER  | accepting result words, one SRAM write register in flight
// DRAIN | all words accepted; waiting for the final write to retire
// DONE  | wb_done high for one cycle
module wb_writeback_unit #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8,
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  wb_writeback_if.slave  bus
);
  localparam int CNT_W = 2 * DIM_W;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_XFER,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DIM_W-1:0]  row_q;
  logic [DIM_W-1:0]  col_q;
  logic [CNT_W-1:0]  total_q;
  logic [CNT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  total_c;
  logic              wb_ack_q;
  logic              wb_done_q;
  logic              mem_wr_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              res_ready_c;
  logic              accept;
  logic              retire;

  // Full-width product so a 255x255 tile is not truncated.
  assign total_c = {{DIM_W{1'b0}}, row_q} * {{DIM_W{1'b0}}, col_q};

  // res_ready must see mem_wait in the same cycle to keep 1 word/cycle
  // throughput, so it is the one combinational output.
  assign res_ready_c = (state == S_XFER) && (!mem_wr_en_q || !bus.mem_wait) &&
                       (acc_q < total_q);
  assign accept      = bus.res_valid && res_ready_c;
  assign retire      = mem_wr_en_q && !bus.mem_wait;

  assign bus.wb_ack    = wb_ack_q;
  assign bus.wb_done   = wb_done_q;
  assign bus.res_ready = res_ready_c;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      total_q     <= '0;
      acc_q       <= '0;
      wb_ack_q    <= 1'b0;
      wb_done_q   <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wb_ack_q  <= 1'b0;
      wb_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.wb_config_valid) begin
            op_q     <= bus.wb_op;
            base_q   <= bus.wb_src_addr;
            row_q    <= bus.wb_row;
            col_q    <= bus.wb_col;
            wb_ack_q <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          if (op_q != 3'b000) begin
            state <= S_IDLE;
          end else if (total_c == '0) begin
            wb_done_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            total_q <= total_c;
            acc_q   <= '0;
            idx_q   <= '0;
            state   <= S_XFER;
          end
        end
        S_XFER: begin
          // A new word replaces the retiring one in the same cycle; only
          // when nothing is loaded does the write request fall.
          if (accept) begin
            mem_wr_en_q <= 1'b1;
            mem_addr_q  <= base_q + idx_q;
            mem_wdata_q <= bus.res_data;
            idx_q       <= idx_q + IDX_ONE;
            acc_q       <= acc_q + CNT_ONE;
            if (acc_q == total_q - CNT_ONE) begin
              state <= S_DRAIN;
            end
          end else if (retire) begin
            mem_wr_en_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!mem_wr_en_q || retire) begin
            mem_wr_en_q <= 1'b0;
            wb_done_q   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_writeback_unit.sv
// Bench for wb_writeback_unit.
// The model is a list of expected (address, data) SRAM writes built from each
// job's base and tile size, plus a result-word source list. A negedge monitor
// checks every retired write against that list, checks stall stability and
// res_ready blocking, and logs ack/done/retire cycles that the directed tests
// compare against hand-computed latencies and addresses.
module tb_wb_writeback_unit;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_writeback_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .DATA_W(DATA_W)) bus();

  wb_writeback_unit #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [DATA_W-1:0] src_mem [256];
  int src_len = 0;
  int src_rd  = 0;

  logic [ADDR_W-1:0] exp_addr [256];
  logic [DATA_W-1:0] exp_data [256];
  int exp_len = 0;
  int exp_rd  = 0;

  int ret_total = 0;
  int ret_cyc [256];
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_data = '0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int stall_tot = 0;
  int stall_at = -1;
  int stall_len = 0;
  int stall_key = -1;
  int stall_run = 0;
  logic prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // SRAM stall generator: holds mem_wait for stall_len cycles on write stall_at.
  initial begin
    bus.mem_wait = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ret_total != stall_key) begin
        stall_key = ret_total;
        stall_run = 0;
      end
      if (bus.mem_wr_en && ret_total == stall_at && stall_run < stall_len) begin
        bus.mem_wait = 1'b1;
        stall_run++;
      end else begin
        bus.mem_wait = 1'b0;
      end
    end
  end

  // Result source: presents src_mem in order, advancing on each handshake.
  initial begin
    bit fire;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    forever begin
      @(negedge clk);
      fire = bus.res_valid && bus.res_ready && rst;
      @(posedge clk); #1;
      if (fire && src_rd < src_len) src_rd++;
      bus.res_valid = (src_rd < src_len);
      bus.res_data  = (src_rd < src_len) ? src_mem[src_rd] : '0;
    end
  end

  // Compare process.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (bus.wb_ack) ack_cnt++;
        if (bus.wb_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (prev_stall) begin
          chk("stall_hold_wr_en", bus.mem_wr_en, 1'b1);
          chk("stall_hold_addr", bus.mem_addr, prev_addr);
          chk("stall_hold_data", bus.mem_wdata, prev_data);
        end
        if (bus.mem_wr_en && bus.mem_wait) begin
          stall_tot++;
          chk("ready_while_blocked", bus.res_ready, 1'b0);
        end
        if (bus.mem_wr_en && !bus.mem_wait) begin
          if (exp_rd < exp_len) begin
            chk("write_addr", bus.mem_addr, exp_addr[exp_rd]);
            chk("write_data", bus.mem_wdata, exp_data[exp_rd]);
            exp_rd++;
          end else begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_write: got write to 0x%0h, want no write", bus.mem_addr);
          end
          ret_cyc[ret_total] = cyc;
          last_addr = bus.mem_addr;
          last_data = bus.mem_wdata;
          ret_total++;
        end
        prev_stall = bus.mem_wr_en && bus.mem_wait;
        prev_addr  = bus.mem_addr;
        prev_data  = bus.mem_wdata;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Model: a write-back job writes word i of the tile to base+i (wrapping).
  task automatic load_job(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                          input int row, input int col, input logic [DATA_W-1:0] d0,
                          input int nsrc);
    int n;
    n = row * col;
    if (op == 3'b000) begin
      for (int i = 0; i < n; i++) begin
        exp_addr[exp_len] = addr + ADDR_W'(i);
        exp_data[exp_len] = d0 + DATA_W'(i);
        exp_len++;
      end
    end
    for (int i = 0; i < nsrc; i++) begin
      src_mem[src_len] = d0 + DATA_W'(i);
      src_len++;
    end
  endtask

  task automatic send_cfg(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DIM_W-1:0] row, input logic [DIM_W-1:0] col,
                          input logic exp_ack, output int ack_at);
    @(posedge clk); #1;
    bus.wb_config_valid = 1'b1;
    bus.wb_op           = op;
    bus.wb_src_addr     = addr;
    bus.wb_row          = row;
    bus.wb_col          = col;
    @(negedge clk);
    chk("cfg_no_early_ack", bus.wb_ack, 1'b0);
    @(posedge clk); #1;
    // Scramble the fields once valid drops: the unit must have sampled them.
    bus.wb_config_valid = 1'b0;
    bus.wb_op           = 3'b111;
    bus.wb_src_addr     = ~addr;
    bus.wb_row          = ~row;
    bus.wb_col          = ~col;
    @(negedge clk); #1;
    chk("cfg_ack", bus.wb_ack, exp_ack);
    ack_at = cyc;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, done_cnt - d0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    int a, a2, r0, d0, k0, s0;
    bus.wb_config_valid = 1'b0;
    bus.wb_op           = '0;
    bus.wb_src_addr     = '0;
    bus.wb_row          = '0;
    bus.wb_col          = '0;

    #2 rst = 1'b0;
    #1;
    chk("rst_ack", bus.wb_ack, 1'b0);
    chk("rst_done", bus.wb_done, 1'b0);
    chk("rst_ready", bus.res_ready, 1'b0);
    chk("rst_wr_en", bus.mem_wr_en, 1'b0);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    idle(3);
    rst = 1'b1;
    idle(2);

    // 1: 2x3 tile at 0x100, full throughput.
    r0 = ret_total; d0 = done_cnt;
    load_job(3'b000, 16'h0100, 2, 3, 32'd1, 6);
    send_cfg(3'b000, 16'h0100, 8'd2, 8'd3, 1'b1, a);
    wait_done(40, "t1_done");
    idle(3);
    chk("t1_nwrites", ret_total - r0, 6);
    chk("t1_first_write_lat", ret_cyc[r0], a + 2);
    for (int i = 1; i < 6; i++) chk("t1_back_to_back", ret_cyc[r0 + i], ret_cyc[r0 + i - 1] + 1);
    chk("t1_done_lat", done_cyc, ret_cyc[r0 + 5] + 1);
    chk("t1_done_single", done_cnt - d0, 1);
    chk("t1_last_addr", last_addr, 16'h0105);
    chk("t1_last_data", last_data, 32'd6);

    // 2: same job, 3-cycle stall on the second write.
    r0 = ret_total; d0 = done_cnt; s0 = stall_tot;
    load_job(3'b000, 16'h0100, 2, 3, 32'h11, 6);
    stall_at = ret_total + 1;
    stall_len = 3;
    send_cfg(3'b000, 16'h0100, 8'd2, 8'd3, 1'b1, a);
    wait_done(60, "t2_done");
    idle(3);
    stall_at = -1;
    chk("t2_nwrites", ret_total - r0, 6);
    chk("t2_stall_cycles", stall_tot - s0, 3);
    chk("t2_second_write_delay", ret_cyc[r0 + 1], ret_cyc[r0] + 4);
    chk("t2_done_lat", done_cyc, ret_cyc[r0 + 5] + 1);
    chk("t2_done_single", done_cnt - d0, 1);
    chk("t2_last_data", last_data, 32'h16);

    // 3a: empty tile -> ack then done, no writes.
    r0 = ret_total;
    send_cfg(3'b000, 16'h0180, 8'd0, 8'd5, 1'b1, a);
    wait_done(10, "t3_empty_done");
    chk("t3_empty_done_lat", done_cyc, a + 1);
    chk("t3_empty_nwrites", ret_total - r0, 0);

    // 3b: non-write-back op -> ack only.
    r0 = ret_total; d0 = done_cnt; k0 = ack_cnt;
    send_cfg(3'b010, 16'h0180, 8'd2, 8'd3, 1'b1, a);
    idle(10);
    chk("t3_op_acks", ack_cnt - k0, 1);
    chk("t3_op_no_done", done_cnt - d0, 0);
    chk("t3_op_nwrites", ret_total - r0, 0);

    // 4: address wrap.
    r0 = ret_total;
    load_job(3'b000, 16'hFFFE, 1, 4, 32'hA0, 4);
    send_cfg(3'b000, 16'hFFFE, 8'd1, 8'd4, 1'b1, a);
    wait_done(40, "t4_done");
    chk("t4_nwrites", ret_total - r0, 4);
    chk("t4_last_addr", last_addr, 16'h0001);

    // 5: second config during XFER is ignored.
    r0 = ret_total; d0 = done_cnt; k0 = ack_cnt;
    load_job(3'b000, 16'h0200, 2, 3, 32'h50, 6);
    send_cfg(3'b000, 16'h0200, 8'd2, 8'd3, 1'b1, a);
    send_cfg(3'b000, 16'h0700, 8'd1, 8'd1, 1'b0, a2);
    wait_done(40, "t5_done");
    idle(6);
    chk("t5_acks", ack_cnt - k0, 1);
    chk("t5_dones", done_cnt - d0, 1);
    chk("t5_nwrites", ret_total - r0, 6);
    chk("t5_last_addr", last_addr, 16'h0205);

    // 6: reset after two of six words, then a clean job.
    r0 = ret_total; d0 = done_cnt;
    load_job(3'b000, 16'h0300, 2, 3, 32'h70, 2);
    send_cfg(3'b000, 16'h0300, 8'd2, 8'd3, 1'b1, a);
    for (int n = 0; n < 30 && ret_total - r0 < 2; n++) idle(1);
    chk("t6_two_words", ret_total - r0, 2);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_ack", bus.wb_ack, 1'b0);
    chk("t6_rst_done", bus.wb_done, 1'b0);
    chk("t6_rst_ready", bus.res_ready, 1'b0);
    chk("t6_rst_wr_en", bus.mem_wr_en, 1'b0);
    chk("t6_rst_addr", bus.mem_addr, 16'h0000);
    chk("t6_rst_wdata", bus.mem_wdata, 32'h0);
    exp_len = exp_rd;
    src_len = src_rd;
    idle(2);
    rst = 1'b1;
    idle(2);
    chk("t6_no_done", done_cnt - d0, 0);
    r0 = ret_total;
    load_job(3'b000, 16'h0400, 1, 2, 32'h80, 2);
    send_cfg(3'b000, 16'h0400, 8'd1, 8'd2, 1'b1, a);
    wait_done(40, "t6_new_done");
    chk("t6_new_nwrites", ret_total - r0, 2);
    chk("t6_new_first_lat", ret_cyc[r0], a + 2);
    chk("t6_new_last_addr", last_addr, 16'h0401);
    chk("t6_new_last_data", last_data, 32'h81);
    chk("t6_exp_drained", exp_len - exp_rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, want bench completion");
    $fatal(1, "bench timeout");
  end
endmodule
